// File: rtl/intt_sched.sv
// Inverse-NTT pass sequencer: issues row-pair read beats with per-beat zeta/permute/scale
// controls, replays them as in-place write-backs PIPE cycles later, and drains between passes.
module intt_sched #(
    parameter int NUM_LAYERS = 7,
    parameter int BEATS      = 4,
    parameter int MEM_LAT    = 1,
    parameter int BFU_LAT    = 3,
    parameter int DO_SCALE   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_rd_en,
    output logic [1:0] o_rd_addr,
    output logic [2:0] o_layer,
    output logic [6:0] o_zeta_base,
    output logic       o_perm_en,
    output logic       o_scale_en,
    output logic       o_wr_en,
    output logic [1:0] o_wr_addr
);

    localparam int         PIPE       = MEM_LAT + BFU_LAT;
    localparam logic [1:0] LAST_BEAT  = 2'(BEATS - 1);
    localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] beat_q, beat_d;
    logic [2:0] layer_q, layer_d;
    logic       scale_q, scale_d;
    logic       issue;
    logic       last_wr;

    logic       rd_en_q, rd_en_d;
    logic [1:0] rd_addr_q, rd_addr_d;
    logic [2:0] layer_out_q, layer_out_d;
    logic [6:0] zeta_q, zeta_d;
    logic       perm_q, perm_d;
    logic       scale_en_q, scale_en_d;

    logic [PIPE-1:0] pipe_en_q, pipe_en_d;
    logic [1:0]      pipe_addr_q [PIPE];
    logic [1:0]      pipe_addr_d [PIPE];

    // Layer l owns zetas (128>>l)-1 down to (64>>l); beat j starts j/BEATS of the way in.
    function automatic logic [6:0] zeta_of(input logic [2:0] l, input logic [1:0] j);
        logic [9:0] top;
        logic [9:0] zl;
        logic [9:0] off;
        top = 10'd128 >> l;
        zl  = 10'd64 >> l;
        off = (10'(j) * zl) / 10'(BEATS);
        return 7'(top - 10'd1 - off);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            layer_q     <= '0;
            scale_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            layer_out_q <= '0;
            zeta_q      <= 7'd127;
            perm_q      <= 1'b0;
            scale_en_q  <= 1'b0;
            pipe_en_q   <= '0;
            for (int i = 0; i < PIPE; i++) pipe_addr_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            layer_q     <= layer_d;
            scale_q     <= scale_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            layer_out_q <= layer_out_d;
            zeta_q      <= zeta_d;
            perm_q      <= perm_d;
            scale_en_q  <= scale_en_d;
            pipe_en_q   <= pipe_en_d;
            for (int i = 0; i < PIPE; i++) pipe_addr_q[i] <= pipe_addr_d[i];
        end
    end

    // A pass may only advance once its final beat has left the write-back pipe.
    assign last_wr = pipe_en_q[PIPE-1] && (pipe_addr_q[PIPE-1] == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        layer_d = layer_q;
        scale_d = scale_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = ISSUE;
                    beat_d  = '0;
                    layer_d = '0;
                    scale_d = 1'b0;
                end
            end
            ISSUE: begin
                if (beat_q == LAST_BEAT) state_d = DRAIN;
                else                     beat_d  = beat_q + 2'd1;
            end
            DRAIN: begin
                if (last_wr) begin
                    beat_d = '0;
                    if (!scale_q && (layer_q < LAST_LAYER)) begin
                        state_d = ISSUE;
                        layer_d = layer_q + 3'd1;
                    end else if ((DO_SCALE != 0) && !scale_q) begin
                        state_d = ISSUE;
                        scale_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue       = (state_d == ISSUE);
        rd_en_d     = issue;
        rd_addr_d   = issue ? beat_d : 2'd0;
        layer_out_d = issue ? (scale_d ? 3'd7 : layer_d) : layer_out_q;
        zeta_d      = issue ? (scale_d ? 7'd0 : zeta_of(layer_d, beat_d)) : zeta_q;
        perm_d      = issue && !scale_d && (layer_d != LAST_LAYER);
        scale_en_d  = issue && scale_d;
        pipe_en_d[0]   = rd_en_q;
        pipe_addr_d[0] = rd_addr_q;
        for (int i = 1; i < PIPE; i++) begin
            pipe_en_d[i]   = pipe_en_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_rd_en     = rd_en_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_layer     = layer_out_q;
    assign o_zeta_base = zeta_q;
    assign o_perm_en   = perm_q;
    assign o_scale_en  = scale_en_q;
    assign o_wr_en     = pipe_en_q[PIPE-1];
    assign o_wr_addr   = pipe_addr_q[PIPE-1];

endmodule

// File: tb/tb_intt_sched.sv
// Self-checking bench for intt_sched: a cycle-offset model of a whole run, a row-in-flight
// scoreboard and a zeta coverage map, with directed and randomized start/reset stimulus.
module tb_intt_sched;

    localparam int NL     = 7;
    localparam int BEATS  = 4;
    localparam int PIPE   = 4;
    localparam int PERIOD = BEATS + PIPE;
    localparam int PASSES = NL + 1;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       o_busy, o_done, o_rd_en, o_perm_en, o_scale_en, o_wr_en;
    logic [1:0] o_rd_addr, o_wr_addr;
    logic [2:0] o_layer;
    logic [6:0] o_zeta_base;

    logic       start_ns = 1'b0;
    logic       ns_busy, ns_done, ns_rd_en, ns_perm_en, ns_scale_en, ns_wr_en;
    logic [1:0] ns_rd_addr, ns_wr_addr;
    logic [2:0] ns_layer;
    logic [6:0] ns_zeta_base;

    int         n_asserts = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rd_cnt, wr_cnt;
    bit [3:0]   inflight;
    bit         cov_on;
    bit         cov [NL][128];

    typedef struct {
        bit busy, done, rd_en, wr_en, perm, scale, in_run;
        int rd_addr, wr_addr, layer, zeta;
    } exp_t;

    intt_sched dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .o_layer(o_layer), .o_zeta_base(o_zeta_base), .o_perm_en(o_perm_en),
        .o_scale_en(o_scale_en), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr)
    );

    intt_sched #(.DO_SCALE(0)) dut_ns (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(start_ns),
        .o_busy(ns_busy), .o_done(ns_done), .o_rd_en(ns_rd_en), .o_rd_addr(ns_rd_addr),
        .o_layer(ns_layer), .o_zeta_base(ns_zeta_base), .o_perm_en(ns_perm_en),
        .o_scale_en(ns_scale_en), .o_wr_en(ns_wr_en), .o_wr_addr(ns_wr_addr)
    );

    always #5 i_clk = ~i_clk;

    // Expected outputs at offset t after the start-sampling cycle of a run with the given pass count.
    function automatic exp_t model(input int t, input int passes);
        exp_t e;
        int   u, p, k, kk;
        e = '{default: 0};
        if (t >= 1 && t <= passes * PERIOD + 1) begin
            e.busy   = 1;
            e.in_run = 1;
            e.done   = (t == passes * PERIOD + 1);
            u  = (t - 1 < passes * PERIOD - 1) ? t - 1 : passes * PERIOD - 1;
            p  = u / PERIOD;
            k  = u % PERIOD;
            kk = (k < BEATS) ? k : BEATS - 1;
            e.zeta = (p < NL) ? (128 >> p) - 1 - (kk * (64 >> p)) / BEATS : 0;
            if (t <= passes * PERIOD) begin
                e.rd_en   = (k < BEATS);
                e.rd_addr = k;
                e.layer   = (p < NL) ? p : 7;
                e.perm    = (p < NL - 1);
                e.scale   = (p >= NL);
                e.wr_en   = (k >= PIPE);
                e.wr_addr = k - PIPE;
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input int t, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s (offset %0d, cycle %0d): observed %0d expected %0d",
                   tag, t, cyc, obs, exp);
        end
    endtask

    task automatic checkCycle(input string who, input int t, input int passes,
                              input logic busy, input logic done, input logic rd_en,
                              input logic [1:0] rd_addr, input logic [2:0] layer,
                              input logic [6:0] zeta, input logic perm, input logic scale,
                              input logic wr_en, input logic [1:0] wr_addr);
        exp_t e;
        e = model(t, passes);
        checkOutput({who, " busy"}, t, 32'(busy), 32'(e.busy));
        checkOutput({who, " done"}, t, 32'(done), 32'(e.done));
        checkOutput({who, " rd_en"}, t, 32'(rd_en), 32'(e.rd_en));
        checkOutput({who, " wr_en"}, t, 32'(wr_en), 32'(e.wr_en));
        if (e.in_run) checkOutput({who, " zeta_base"}, t, 32'(zeta), 32'(e.zeta));
        if (e.rd_en) begin
            checkOutput({who, " rd_addr"}, t, 32'(rd_addr), 32'(e.rd_addr));
            checkOutput({who, " layer"}, t, 32'(layer), 32'(e.layer));
            checkOutput({who, " perm_en"}, t, 32'(perm), 32'(e.perm));
            checkOutput({who, " scale_en"}, t, 32'(scale), 32'(e.scale));
        end
        if (e.wr_en) checkOutput({who, " wr_addr"}, t, 32'(wr_addr), 32'(e.wr_addr));
    endtask

    task automatic checkReset(input string tag, input int t);
        checkOutput({tag, " busy"}, t, 32'(o_busy), 0);
        checkOutput({tag, " done"}, t, 32'(o_done), 0);
        checkOutput({tag, " rd_en"}, t, 32'(o_rd_en), 0);
        checkOutput({tag, " rd_addr"}, t, 32'(o_rd_addr), 0);
        checkOutput({tag, " layer"}, t, 32'(o_layer), 0);
        checkOutput({tag, " zeta_base"}, t, 32'(o_zeta_base), 127);
        checkOutput({tag, " perm_en"}, t, 32'(o_perm_en), 0);
        checkOutput({tag, " scale_en"}, t, 32'(o_scale_en), 0);
        checkOutput({tag, " wr_en"}, t, 32'(o_wr_en), 0);
        checkOutput({tag, " wr_addr"}, t, 32'(o_wr_addr), 0);
    endtask

    // Row-pair hazard scoreboard plus zeta coverage marking for the main DUT.
    task automatic scoreboard(input int t);
        int n;
        if (o_wr_en) begin
            checkOutput("write of row pair not in flight", t, 32'(inflight[o_wr_addr]), 1);
            inflight[o_wr_addr] = 1'b0;
            wr_cnt++;
        end
        if (o_rd_en) begin
            checkOutput("read of row pair in flight", t,
                        32'(inflight[o_rd_addr] || (o_wr_en && o_wr_addr == o_rd_addr)), 0);
            inflight[o_rd_addr] = 1'b1;
            rd_cnt++;
            if (cov_on && o_layer < 3'(NL)) begin
                n = (64 >> o_layer) / BEATS;
                if (n < 1) n = 1;
                for (int z = 0; z < n; z++)
                    if (int'(o_zeta_base) - z >= 0) cov[o_layer][int'(o_zeta_base) - z] = 1'b1;
            end
        end
    endtask

    // kind 0: no start during run; 1: start at offset 10 and in DONE; 2: random start noise.
    task automatic applyStimulus(input int t, input int kind);
        case (kind)
            1:       i_start = (t == 10) || (t == PASSES * PERIOD + 1);
            2:       i_start = 1'($urandom_range(0, 1));
            default: i_start = 1'b0;
        endcase
    endtask

    // Caller has i_start = 1 in the current cycle (offset 0).
    task automatic runAndCheck(input int kind, input int rst_at, input bit with_ns);
        rd_cnt   = 0;
        wr_cnt   = 0;
        inflight = '0;
        for (int t = 1; t <= PASSES * PERIOD + 1; t++) begin
            tick();
            start_ns = 1'b0;
            if (rst_at > 0 && t > rst_at) begin
                i_rst   = 1'b0;
                i_start = 1'b0;
                checkReset("after reset", t);
                if (t >= rst_at + 12) break;
                continue;
            end
            checkCycle("main", t, PASSES, o_busy, o_done, o_rd_en, o_rd_addr, o_layer,
                       o_zeta_base, o_perm_en, o_scale_en, o_wr_en, o_wr_addr);
            if (with_ns)
                checkCycle("noscale", t, NL, ns_busy, ns_done, ns_rd_en, ns_rd_addr, ns_layer,
                           ns_zeta_base, ns_perm_en, ns_scale_en, ns_wr_en, ns_wr_addr);
            scoreboard(t);
            applyStimulus(t, kind);
            if (rst_at > 0 && t == rst_at) begin
                i_rst    = 1'b1;
                inflight = '0;
            end
        end
        if (rst_at <= 0) begin
            checkOutput("read beats per run", 0, 32'(rd_cnt), 32'(PASSES * BEATS));
            checkOutput("write beats per run", 0, 32'(wr_cnt), 32'(PASSES * BEATS));
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy"}, 0, 32'(o_busy), 0);
        checkOutput({tag, " rd_en"}, 0, 32'(o_rd_en), 0);
        checkOutput({tag, " wr_en"}, 0, 32'(o_wr_en), 0);
    endtask

    initial begin
        int once, total, hits, gap;

        // Reset state, with start held high to confirm reset dominance.
        i_start = 1'b1;
        tick();
        tick();
        checkReset("reset state", 0);
        i_rst   = 1'b0;
        i_start = 1'b0;
        tick();
        checkReset("idle after reset", 0);

        // Single run alongside the no-scale instance, with zeta coverage collection.
        $display("[TB] run 1: single start, DO_SCALE=1 and DO_SCALE=0");
        for (int l = 0; l < NL; l++)
            for (int z = 0; z < 128; z++) cov[l][z] = 1'b0;
        cov_on   = 1'b1;
        i_start  = 1'b1;
        start_ns = 1'b1;
        runAndCheck(0, -1, 1'b1);
        cov_on = 1'b0;
        once  = 0;
        total = 0;
        for (int z = 0; z < 128; z++) begin
            hits = 0;
            for (int l = 0; l < NL; l++) hits += int'(cov[l][z]);
            total += hits;
            if (z >= 1 && hits == 1) once++;
        end
        checkOutput("zetas covered exactly once", 0, 32'(once), 127);
        checkOutput("total zeta uses", 0, 32'(total), 127);
        tick();
        checkIdle("idle after run 1");

        // Start pulses while busy and in DONE are ignored; restart in the cycle after done.
        $display("[TB] run 2: start at offsets 10 and 65");
        i_start = 1'b1;
        runAndCheck(1, -1, 1'b0);
        tick();
        checkIdle("idle after run 2");
        $display("[TB] run 3: restart at offset 66 with random start noise");
        i_start = 1'b1;
        runAndCheck(2, -1, 1'b0);
        tick();
        checkIdle("idle after run 3");

        // Mid-run reset, then a clean run after a random idle gap.
        $display("[TB] run 4: reset at offset 20");
        i_start = 1'b1;
        runAndCheck(2, 20, 1'b0);
        gap = $urandom_range(1, 5);
        for (int i = 0; i < gap; i++) begin
            tick();
            checkReset("idle gap", i);
        end
        $display("[TB] run 5: normal run after reset");
        i_start = 1'b1;
        runAndCheck(0, -1, 1'b0);
        tick();
        checkIdle("idle after run 5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
